lc3_mem_responder: RTL and testbench

//  Parametrised dual-channel memory model that serves the LC3 core's instruction and data ports.

---
 rtl/lc3_mem_responder_if.sv | 27 ++
 rtl/lc3_mem_responder.sv | 198 +++++++++++++++++++
 tb/tb_lc3_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_responder_if.sv
// rtl/lc3_mem_responder_if.sv - LC3 instruction/data port bundle between core (master) and memory (slave)
interface lc3_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              instrmem_rd;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] Instr_dout;
    logic              complete_instr;

    logic              data_req;
    logic              Data_rd;
    logic [ADDR_W-1:0] Data_addr;
    logic [DATA_W-1:0] Data_din;
    logic [DATA_W-1:0] Data_dout;
    logic              complete_data;

    modport master (
        output instrmem_rd, pc, data_req, Data_rd, Data_addr, Data_din,
        input  Instr_dout, complete_instr, Data_dout, complete_data
    );

    modport slave (
        input  instrmem_rd, pc, data_req, Data_rd, Data_addr, Data_din,
        output Instr_dout, complete_instr, Data_dout, complete_data
    );
endinterface

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - dual-channel LC3 memory model with wait states; LC3_MEM_RAND_LAT_EN enables LFSR latency
module lc3_mem_responder #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter int                DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h3000,
    parameter int                T_FETCH    = 0,
    parameter int                T_DATA     = 0,
    parameter logic [7:0]        LFSR_SEED  = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    lc3_mem_responder_if.slave  bus,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [DATA_W-1:0]   load_data,
    output logic                addr_err,
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         rd_cnt,
    output logic [31:0]         wr_cnt
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LAT_W = 16;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    if (LFSR_SEED == 8'h00) begin : g_seed_check
        $error("LFSR_SEED must be nonzero");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            f_state_q, d_state_q;
    logic [LAT_W-1:0]  f_wait_q, d_wait_q;
    logic [ADDR_W-1:0] f_addr_q, d_addr_q;
    logic              d_rd_q;
    logic [DATA_W-1:0] d_din_q;
    logic              complete_instr_q, complete_data_q;
    logic [DATA_W-1:0] instr_dout_q, data_dout_q;
    logic [31:0]       fetch_cnt_q, rd_cnt_q, wr_cnt_q;
    logic              addr_err_q;

    logic [LAT_W-1:0]  f_lat_d, d_lat_d;
    logic [ADDR_W-1:0] f_addr_d, d_addr_d;
    logic [DATA_W-1:0] d_din_d;
    logic              d_rd_d;
    logic              f_resp_d, d_resp_d;

    function automatic logic in_win(input logic [ADDR_W-1:0] a);
        return ((a - BASE_ADDR) >> DEPTH_LOG2) == '0;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] mem_index(input logic [ADDR_W-1:0] a);
        return DEPTH_LOG2'(a - BASE_ADDR);
    endfunction

    function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
        return in_win(a) ? mem_q[mem_index(a)] : '0;
    endfunction

`ifdef LC3_MEM_RAND_LAT_EN
    logic [7:0] f_lfsr_q, d_lfsr_q;

    // x^8+x^6+x^5+x^4+1, stepped only when a request is accepted
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always_comb begin
        f_lat_d = LAT_W'(32'(f_lfsr_q) % (T_FETCH + 1));
        d_lat_d = LAT_W'(32'(d_lfsr_q) % (T_DATA + 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_lfsr_q <= LFSR_SEED;
            d_lfsr_q <= LFSR_SEED;
        end else begin
            if ((f_state_q == IDLE) && bus.instrmem_rd) f_lfsr_q <= lfsr_next(f_lfsr_q);
            if ((d_state_q == IDLE) && bus.data_req)    d_lfsr_q <= lfsr_next(d_lfsr_q);
        end
    end
`else
    always_comb begin
        f_lat_d = LAT_W'(T_FETCH);
        d_lat_d = LAT_W'(T_DATA);
    end
`endif

    // Outside IDLE the captured request is used; live bus values are ignored.
    always_comb begin
        f_addr_d = (f_state_q == IDLE) ? bus.pc        : f_addr_q;
        d_addr_d = (d_state_q == IDLE) ? bus.Data_addr : d_addr_q;
        d_rd_d   = (d_state_q == IDLE) ? bus.Data_rd   : d_rd_q;
        d_din_d  = (d_state_q == IDLE) ? bus.Data_din  : d_din_q;
        f_resp_d = bus.instrmem_rd &&
                   (((f_state_q == IDLE) && (f_lat_d == '0)) || ((f_state_q == WAIT) && (f_wait_q == '0)));
        d_resp_d = bus.data_req &&
                   (((d_state_q == IDLE) && (d_lat_d == '0)) || ((d_state_q == WAIT) && (d_wait_q == '0)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_state_q        <= IDLE;
            f_wait_q         <= '0;
            f_addr_q         <= '0;
            complete_instr_q <= 1'b0;
            instr_dout_q     <= '0;
            fetch_cnt_q      <= '0;
        end else if (f_resp_d) begin
            f_state_q        <= RESP;
            f_addr_q         <= f_addr_d;
            complete_instr_q <= 1'b1;
            instr_dout_q     <= rd_word(f_addr_d);
            if (fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end else begin
            complete_instr_q <= 1'b0;
            instr_dout_q     <= '0;
            unique case (f_state_q)
                IDLE: if (bus.instrmem_rd) begin
                    f_state_q <= WAIT;
                    f_addr_q  <= bus.pc;
                    f_wait_q  <= f_lat_d - LAT_W'(1);
                end
                WAIT: if (!bus.instrmem_rd) f_state_q <= IDLE;
                      else                  f_wait_q  <= f_wait_q - LAT_W'(1);
                RESP:    f_state_q <= IDLE;
                default: f_state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_state_q       <= IDLE;
            d_wait_q        <= '0;
            d_addr_q        <= '0;
            d_rd_q          <= 1'b0;
            d_din_q         <= '0;
            complete_data_q <= 1'b0;
            data_dout_q     <= '0;
            rd_cnt_q        <= '0;
            wr_cnt_q        <= '0;
        end else if (d_resp_d) begin
            d_state_q       <= RESP;
            d_addr_q        <= d_addr_d;
            d_rd_q          <= d_rd_d;
            d_din_q         <= d_din_d;
            complete_data_q <= 1'b1;
            data_dout_q     <= d_rd_d ? rd_word(d_addr_d) : '0;
            if (d_rd_d) begin
                if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
            end else begin
                if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end else begin
            complete_data_q <= 1'b0;
            data_dout_q     <= '0;
            unique case (d_state_q)
                IDLE: if (bus.data_req) begin
                    d_state_q <= WAIT;
                    d_addr_q  <= bus.Data_addr;
                    d_rd_q    <= bus.Data_rd;
                    d_din_q   <= bus.Data_din;
                    d_wait_q  <= d_lat_d - LAT_W'(1);
                end
                WAIT: if (!bus.data_req) d_state_q <= IDLE;
                      else               d_wait_q  <= d_wait_q - LAT_W'(1);
                RESP:    d_state_q <= IDLE;
                default: d_state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            addr_err_q <= 1'b0;
        else if ((f_resp_d && !in_win(f_addr_d)) || (d_resp_d && !in_win(d_addr_d)))
            addr_err_q <= 1'b1;
    end

    // Write commits at the end of RESP; the preload is applied last so it wins a same-index clash.
    always_ff @(posedge clk) begin
        if (!reset && (d_state_q == RESP) && !d_rd_q && in_win(d_addr_q))
            mem_q[mem_index(d_addr_q)] <= d_din_q;
        if (load_en && in_win(load_addr))
            mem_q[mem_index(load_addr)] <= load_data;
    end

    assign bus.Instr_dout     = instr_dout_q;
    assign bus.complete_instr = complete_instr_q;
    assign bus.Data_dout      = data_dout_q;
    assign bus.complete_data  = complete_data_q;
    assign addr_err           = addr_err_q;
    assign fetch_cnt          = fetch_cnt_q;
    assign rd_cnt             = rd_cnt_q;
    assign wr_cnt             = wr_cnt_q;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb/tb_lc3_mem_responder.sv - randomized self-checking bench for lc3_mem_responder against a behavioural model
module tb_lc3_mem_responder;
    localparam int T_FETCH = 0;
    localparam int T_DATA  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [15:0] load_addr, load_data;
    logic        addr_err;
    logic [31:0] fetch_cnt, rd_cnt, wr_cnt;

    always #5 clk = ~clk;

    lc3_mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    lc3_mem_responder #(.T_FETCH(T_FETCH), .T_DATA(T_DATA)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .addr_err  (addr_err),
        .fetch_cnt (fetch_cnt),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] ref_mem [4096];
    logic [31:0] ref_fetch, ref_rd, ref_wr;
    logic        ref_err;

`ifdef LC3_MEM_RAND_LAT_EN
    int f_lfsr, d_lfsr;
    bit lat_seen [16];

    function automatic int lfsr_adv(input int s);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s << 1) | fb) & 255;
    endfunction
`endif

    function automatic int fetch_lat();
`ifdef LC3_MEM_RAND_LAT_EN
        int l;
        l = f_lfsr % (T_FETCH + 1);
        f_lfsr = lfsr_adv(f_lfsr);
        return l;
`else
        return T_FETCH;
`endif
    endfunction

    function automatic int data_lat();
`ifdef LC3_MEM_RAND_LAT_EN
        int l;
        l = d_lfsr % (T_DATA + 1);
        d_lfsr = lfsr_adv(d_lfsr);
        return l;
`else
        return T_DATA;
`endif
    endfunction

    function automatic int widx(input logic [15:0] a);
        return (int'(a) - 'h3000) & 'hFFFF;
    endfunction

    function automatic bit in_win(input logic [15:0] a);
        return widx(a) < 4096;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_fetch = 0;
        ref_rd    = 0;
        ref_wr    = 0;
        ref_err   = 1'b0;
`ifdef LC3_MEM_RAND_LAT_EN
        f_lfsr = 'hA5;
        d_lfsr = 'hA5;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.instrmem_rd = 1'b0;
        bus.data_req    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_load(input logic [15:0] addr, input logic [15:0] val);
        @(negedge clk);
        load_en = 1'b1; load_addr = addr; load_data = val;
        if (in_win(addr)) ref_mem[widx(addr)] = val;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic do_fetch(input logic [15:0] addr);
        int lat, cyc;
        logic [15:0] exp_w;
        @(negedge clk);
        bus.instrmem_rd = 1'b1;
        bus.pc          = addr;
        lat   = fetch_lat();
        exp_w = in_win(addr) ? ref_mem[widx(addr)] : 16'h0;
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
            bus.pc = 16'($urandom);
        end while (!bus.complete_instr && cyc < 40);
        check_eq("fetch_lat", cyc, lat + 1);
        check_eq("fetch_data", bus.Instr_dout, exp_w);
        ref_fetch++;
        if (!in_win(addr)) ref_err = 1'b1;
        check_eq("fetch_cnt", fetch_cnt, ref_fetch);
        check_eq("fetch_addr_err", addr_err, ref_err);
        bus.instrmem_rd = 1'b0;
    endtask

    // mode 0: plain access, 1: same-index preload in the RESP cycle, 2: reset in the RESP cycle
    task automatic do_data(input logic [15:0] addr, input bit rd, input logic [15:0] din,
                           input int mode, input logic [15:0] ld);
        int lat, cyc;
        logic [15:0] exp_w;
        @(negedge clk);
        bus.data_req  = 1'b1;
        bus.Data_rd   = rd;
        bus.Data_addr = addr;
        bus.Data_din  = din;
        lat   = data_lat();
        exp_w = (rd && in_win(addr)) ? ref_mem[widx(addr)] : 16'h0;
        cyc   = 0;
        do begin
            @(negedge clk);
            cyc++;
            bus.Data_addr = 16'($urandom);
            bus.Data_din  = 16'($urandom);
            bus.Data_rd   = 1'($urandom);
        end while (!bus.complete_data && cyc < 40);
`ifdef LC3_MEM_RAND_LAT_EN
        if (cyc < 16) lat_seen[cyc] = 1'b1;
`endif
        check_eq(rd ? "rd_lat" : "wr_lat", cyc, lat + 1);
        check_eq(rd ? "rd_data" : "wr_dout", bus.Data_dout, exp_w);
        if (rd) ref_rd++; else ref_wr++;
        if (!in_win(addr)) ref_err = 1'b1;
        check_eq("rd_cnt", rd_cnt, ref_rd);
        check_eq("wr_cnt", wr_cnt, ref_wr);
        check_eq("data_addr_err", addr_err, ref_err);
        bus.data_req = 1'b0;
        if (mode == 1) begin
            load_en = 1'b1; load_addr = addr; load_data = ld;
            @(negedge clk);
            load_en = 1'b0;
            if (in_win(addr)) ref_mem[widx(addr)] = ld;
        end else if (mode == 2) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            model_reset();
        end else if (!rd && in_win(addr)) begin
            ref_mem[widx(addr)] = din;
        end
    endtask

    task automatic do_abort(input logic [15:0] addr);
        int lat, seen, cyc;
        @(negedge clk);
        bus.data_req = 1'b1; bus.Data_rd = 1'b1; bus.Data_addr = addr;
        lat = data_lat();
        if (lat >= 2) begin
            seen = 0;
            repeat (2) begin @(negedge clk); seen += int'(bus.complete_data); end
            bus.data_req = 1'b0;
            repeat (8) begin @(negedge clk); seen += int'(bus.complete_data); end
            check_eq("abort_no_complete", seen, 0);
            check_eq("abort_rd_cnt", rd_cnt, ref_rd);
        end else begin
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (!bus.complete_data && cyc < 40);
            check_eq("abort_short_lat", cyc, lat + 1);
            ref_rd++;
            bus.data_req = 1'b0;
        end
    endtask

    initial begin
        int k;
        logic [15:0] a1, a2;
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        bus.instrmem_rd = 1'b0; bus.pc = '0;
        bus.data_req = 1'b0; bus.Data_rd = 1'b0; bus.Data_addr = '0; bus.Data_din = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_complete_instr", bus.complete_instr, 0);
        check_eq("rst_complete_data", bus.complete_data, 0);
        check_eq("rst_instr_dout", bus.Instr_dout, 0);
        check_eq("rst_data_dout", bus.Data_dout, 0);
        check_eq("rst_addr_err", addr_err, 0);
        check_eq("rst_fetch_cnt", fetch_cnt, 0);
        check_eq("rst_rd_cnt", rd_cnt, 0);
        check_eq("rst_wr_cnt", wr_cnt, 0);
        reset = 1'b0;

        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = 16'h3000 + 16'(i);
            load_data = 16'($urandom);
            ref_mem[i] = load_data;
        end
        @(negedge clk);
        load_en = 1'b0;
        ref_mem[0] = 16'h1234;
        do_load(16'h3000, 16'h1234);
        do_load(16'h3010, 16'h0000);
        do_reset();

        do_fetch(16'h3000);
        do_data(16'h3005, 1'b0, 16'hBEEF, 0, 16'h0);
        do_data(16'h3005, 1'b1, 16'h0, 0, 16'h0);
        do_abort(16'h3006);
        do_data(16'h3006, 1'b1, 16'h0, 0, 16'h0);

        @(negedge clk);
        bus.instrmem_rd = 1'b1; bus.pc = 16'h3000; k = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.complete_instr) begin
                check_eq("b2b_cycle", c, 2 * k + 1);
                check_eq("b2b_data", bus.Instr_dout, ref_mem[k]);
                void'(fetch_lat());
                k++;
                bus.pc = 16'h3000 + 16'(k);
            end
        end
        bus.instrmem_rd = 1'b0;
        ref_fetch += 32'(k);
        check_eq("b2b_count", k, 5);
        @(negedge clk);
        check_eq("b2b_fetch_cnt", fetch_cnt, ref_fetch);

        do_data(16'h3020, 1'b0, 16'h5555, 1, 16'hAAAA);
        do_data(16'h3020, 1'b1, 16'h0, 0, 16'h0);

        do_data(16'h2FFF, 1'b1, 16'h0, 0, 16'h0);
        do_data(16'h4000, 1'b0, 16'hDEAD, 0, 16'h0);
        do_fetch(16'h3FFF);
        do_fetch(16'h4000);

        do_data(16'h3010, 1'b0, 16'hABCD, 2, 16'h0);
        check_eq("post_rst_addr_err", addr_err, 0);
        check_eq("post_rst_rd_cnt", rd_cnt, 0);
        check_eq("post_rst_wr_cnt", wr_cnt, 0);
        check_eq("post_rst_fetch_cnt", fetch_cnt, 0);
        check_eq("post_rst_complete", bus.complete_data, 0);
        do_data(16'h3010, 1'b1, 16'h0, 0, 16'h0);

        for (int it = 0; it < 150; it++) begin
            a1 = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'h3000 + 16'($urandom_range(0, 4095));
            a2 = 16'h3000 + 16'($urandom_range(0, 4095));
            case ($urandom_range(0, 3))
                0: do_fetch(a1);
                1: do_data(a1, 1'b1, 16'h0, 0, 16'h0);
                2: do_data(a1, 1'b0, 16'($urandom), 0, 16'h0);
                default: begin
                    a1 = 16'h3000 + 16'($urandom_range(0, 4095));
                    fork
                        do_fetch(a1);
                        do_data(a2, 1'b1, 16'h0, 0, 16'h0);
                    join
                end
            endcase
        end

`ifdef LC3_MEM_RAND_LAT_EN
        k = 0;
        for (int i = 0; i < 16; i++) k += int'(lat_seen[i]);
        check_eq("distinct_latencies", k >= 4, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
